// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment digit scanner with per-slot blanking and per-frame input snapshot.
// Optional macro LEADING_ZERO_BLANK_EN suppresses enables for digits above the highest nonzero one.
module seg_scan_mux #(
  parameter int NUM_DIGITS       = 4,
  parameter int DIGIT_W          = 3,
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 1000,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_digits,
  output logic [DIGIT_W-1:0]            o_digit_val,
  output logic [NUM_DIGITS-1:0]         o_digit_en,
  output logic                          o_frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF = (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                     : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                        state_r, state_s;
  logic [IDX_W-1:0]              idx_r, idx_s;
  logic [CNT_W-1:0]              cnt_r, cnt_s;
  logic [NUM_DIGITS*DIGIT_W-1:0] snap_r, snap_s;
  logic                          capture_s;
  logic                          tick_s;
  logic                          show_ok_s;
  logic [DIGIT_W-1:0]            val_s;
  logic [NUM_DIGITS-1:0]         on_s;
  logic [NUM_DIGITS-1:0]         en_s;

  // Next-state logic: the slot counter runs across blank and show so each slot is REFRESH_DIV long.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    cnt_s     = cnt_r;
    snap_s    = snap_r;
    capture_s = 1'b0;
    tick_s    = 1'b0;
    if (!i_enable) begin
      state_s = ST_IDLE;
      idx_s   = {IDX_W{1'b0}};
      cnt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          idx_s     = {IDX_W{1'b0}};
          cnt_s     = {CNT_W{1'b0}};
          snap_s    = i_digits;
          capture_s = 1'b1;
          state_s   = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
        end
        ST_BLANK: begin
          cnt_s = cnt_r + CNT_W'(1);
          if (cnt_r == BLANK_LAST) begin
            state_s = ST_SHOW;
          end else begin
            state_s = ST_BLANK;
          end
        end
        ST_SHOW: begin
          if (cnt_r == SLOT_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
            if (idx_r == IDX_LAST) begin
              idx_s     = {IDX_W{1'b0}};
              snap_s    = i_digits;
              capture_s = 1'b1;
              tick_s    = 1'b1;
            end else begin
              idx_s = idx_r + IDX_W'(1);
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = ST_IDLE;
          idx_s   = {IDX_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] hi_r, hi_s;

  function automatic logic [IDX_W-1:0] highest_nz(input logic [NUM_DIGITS*DIGIT_W-1:0] w);
    highest_nz = {IDX_W{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w[k*DIGIT_W +: DIGIT_W] != {DIGIT_W{1'b0}}) highest_nz = IDX_W'(k);
    end
  endfunction

  // Highest displayed digit, refreshed together with the snapshot.
  always_comb begin
    hi_s = hi_r;
    if (capture_s) begin
      hi_s = highest_nz(i_digits);
    end else begin
      hi_s = hi_r;
    end
    show_ok_s = (idx_s <= hi_s);
  end

  // Leading-zero limit register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) hi_r <= {IDX_W{1'b0}};
    else          hi_r <= hi_s;
  end
`else
  // Every digit lights in its show phase.
  always_comb begin
    show_ok_s = 1'b1;
  end
`endif

  // Output decode from next-state values so the registered outputs line up with the state.
  always_comb begin
    on_s = {NUM_DIGITS{1'b0}};
    if (state_s == ST_IDLE) begin
      val_s = {DIGIT_W{1'b0}};
    end else begin
      val_s = snap_s[int'(idx_s)*DIGIT_W +: DIGIT_W];
    end
    if ((state_s == ST_SHOW) && show_ok_s) begin
      on_s = NUM_DIGITS'(1) << idx_s;
    end else begin
      on_s = {NUM_DIGITS{1'b0}};
    end
    en_s = (DIGIT_ACTIVE_LOW != 0) ? ~on_s : on_s;
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= {IDX_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      snap_r       <= {(NUM_DIGITS*DIGIT_W){1'b0}};
      o_digit_val  <= {DIGIT_W{1'b0}};
      o_digit_en   <= EN_OFF;
      o_frame_tick <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      cnt_r        <= cnt_s;
      snap_r       <= snap_s;
      o_digit_val  <= val_s;
      o_digit_en   <= en_s;
      o_frame_tick <= tick_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a slot/frame arithmetic model queues expected outputs per cycle.
// Two instances: 4 digits / 8-cycle slot / 2 blank, and 1 digit / 8-cycle slot / no blank.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [11:0] digits;
  logic [2:0]  val_a, val_b;
  logic [3:0]  en_a;
  logic [0:0]  en_b;
  logic        tick_a, tick_b;

  always #5 clk = ~clk;

  seg_scan_mux #(.NUM_DIGITS(4), .DIGIT_W(3), .REFRESH_DIV(8), .BLANK_CYCLES(2),
                 .DIGIT_ACTIVE_LOW(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_digits(digits),
    .o_digit_val(val_a), .o_digit_en(en_a), .o_frame_tick(tick_a));

  seg_scan_mux #(.NUM_DIGITS(1), .DIGIT_W(3), .REFRESH_DIV(8), .BLANK_CYCLES(0),
                 .DIGIT_ACTIVE_LOW(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_digits(digits[2:0]),
    .o_digit_val(val_b), .o_digit_en(en_b), .o_frame_tick(tick_b));

  typedef struct packed {
    logic [2:0] val;
    logic [3:0] en;
    logic       tick;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   tests = 0;
  int   fails = 0;

  int          t_a = 0, t_b = 0;
  bit          run_a = 0, run_b = 0, tk_a = 0, tk_b = 0;
  logic [11:0] snap_a = 12'd0, snap_b = 12'd0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Expected outputs from slot position t: digit = (t/R)%N, lit once t%R reaches B.
  function automatic exp_t predict(input int n, input int r, input int b, input bit run,
                                   input int t, input logic [11:0] snap, input bit tick);
    exp_t       e;
    int         d;
    bit         show;
    logic [3:0] mask;
    logic [3:0] one;
    mask   = 4'((1 << n) - 1);
    one    = 4'd1;
    e.val  = 3'd0;
    e.en   = mask;
    e.tick = 1'b0;
    if (run) begin
      d     = (t / r) % n;
      e.val = 3'((snap >> (3 * d)) & 12'd7);
      show  = (t % r) >= b;
`ifdef LEADING_ZERO_BLANK_EN
      begin
        int h;
        h = 0;
        for (int k = 0; k < n; k++) if (((snap >> (3 * k)) & 12'd7) != 12'd0) h = k;
        show = show && (d <= h);
      end
`endif
      if (show) e.en = mask & ~(one << d);
      e.tick = tick;
    end
    return e;
  endfunction

  // Advance both models by one clock edge using the inputs that edge sampled.
  task automatic advance();
    if (!en) begin
      run_a = 0; run_b = 0; tk_a = 0; tk_b = 0;
    end else begin
      if (!run_a) begin
        run_a = 1; t_a = 0; snap_a = digits; tk_a = 0;
      end else begin
        t_a++;
        tk_a = (t_a % 32) == 0;
        if (tk_a) snap_a = digits;
      end
      if (!run_b) begin
        run_b = 1; t_b = 0; snap_b = {9'd0, digits[2:0]}; tk_b = 0;
      end else begin
        t_b++;
        tk_b = (t_b % 8) == 0;
        if (tk_b) snap_b = {9'd0, digits[2:0]};
      end
    end
    q_a.push_back(predict(4, 8, 2, run_a, t_a, snap_a, tk_a));
    q_b.push_back(predict(1, 8, 0, run_b, t_b, snap_b, tk_b));
  endtask

  task automatic cyc(input bit e, input logic [11:0] d);
    en     = e;
    digits = d;
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_val_a"}, int'(val_a), 0);
    chk({tag, "_en_a"}, int'(en_a), 15);
    chk({tag, "_tick_a"}, int'(tick_a), 0);
    chk({tag, "_val_b"}, int'(val_b), 0);
    chk({tag, "_en_b"}, int'(en_b), 1);
    chk({tag, "_tick_b"}, int'(tick_b), 0);
  endtask

  // Monitor: every cycle's outputs are compared with the oldest queued expectation.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      chk("val_a", int'(val_a), int'(ea.val));
      chk("en_a", int'(en_a), int'(ea.en));
      chk("tick_a", int'(tick_a), int'(ea.tick));
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      chk("val_b", int'(val_b), int'(eb.val));
      chk("en_b", int'(en_b), int'(eb.en[0]));
      chk("tick_b", int'(tick_b), int'(eb.tick));
    end
  end

  logic [11:0] d1, d7, dlz, rnd;
  int          guard;

  initial begin
    d1  = {3'd4, 3'd3, 3'd2, 3'd1};
    d7  = {3'd7, 3'd7, 3'd7, 3'd7};
    dlz = {3'd0, 3'd0, 3'd5, 3'd0};
    rst_n  = 1'b0;
    en     = 1'b0;
    digits = 12'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) cyc(1'b0, 12'($urandom));
    for (int i = 0; i < 74; i++) cyc(1'b1, d1);
    for (int i = 0; i < 60; i++) cyc(1'b1, d7);
    guard = 0;
    while ((t_a % 32) != 20 && guard < 64) begin
      cyc(1'b1, d1);
      guard++;
    end
    chk("reach_digit2_show", t_a % 32, 20);
    for (int i = 0; i < 3; i++) cyc(1'b0, d1);
    for (int i = 0; i < 70; i++) cyc(1'b1, dlz);
    for (int i = 0; i < 40; i++) cyc(1'b1, 12'd0);

    rnd = 12'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) rnd = 12'($urandom) & 12'($urandom);
      cyc($urandom_range(0, 39) != 0, rnd);
    end

    for (int i = 0; i < 13; i++) cyc(1'b1, d1);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    #1 rst_n = 1'b1;
    run_a = 0; run_b = 0; tk_a = 0; tk_b = 0;
    for (int i = 0; i < 40; i++) cyc(1'b1, d1);

    @(negedge clk);
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexes NUM_DIGITS packed digit values onto one shared 7-segment decoder.
- Sits directly upstream of the hex-to-7-segment decoder stage. o_digit_val drives the decoder's 3-bit value input, and o_digit_en drives the per-digit common pins.
- Inserts a blanking gap between digits to prevent ghosting.
- Snapshots the input word once per frame so all digits of a frame display consistently.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (>=1).
- DIGIT_W, 3: bits per digit value; matches decoder input width.
- REFRESH_DIV, 50000: clock cycles per digit slot, blank plus show (> BLANK_CYCLES).
- BLANK_CYCLES, 1000: cycles per slot with all digits off (0 allowed; 0 means no blank phase).
- DIGIT_ACTIVE_LOW, 1: 1 = o_digit_en bit low turns the digit on; 0 = high turns it on.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  1 = scanning runs; 0 = display dark.
- i_digits  input  NUM_DIGITS*DIGIT_W  packed values; digit k = bits [k*DIGIT_W +: DIGIT_W]; digit 0 = least significant/rightmost.
- o_digit_val  output  DIGIT_W  value of the current digit, to the decoder.
- o_digit_en  output  NUM_DIGITS  one-hot digit enables, polarity per DIGIT_ACTIVE_LOW.
- o_frame_tick  output  1  one-cycle pulse on each frame wrap.

Behaviour:
- Interface: single clock i_clk; reset i_rst_n is asynchronous, active-low. All outputs are registered.
- Reset values:
  - state IDLE; idx 0; slot counter 0; snapshot 0.
  - o_digit_val 0; o_frame_tick 0.
  - o_digit_en all inactive: all 1s if DIGIT_ACTIVE_LOW, else all 0s.
- States:
  - IDLE: all digits off; counter held at 0.
  - BLANK: all digits off; o_digit_val = snap[idx].
  - SHOW: only digit idx enabled; o_digit_val = snap[idx].
- IDLE -> BLANK:
  - Occurs on the first edge with i_enable=1.
  - idx=0; snapshot <= i_digits; counter=0.
- BLANK -> SHOW:
  - Occurs after BLANK_CYCLES cycles in BLANK (counter 0..BLANK_CYCLES-1).
  - If BLANK_CYCLES=0, BLANK is bypassed: IDLE and slot-end go straight to SHOW.
- SHOW -> BLANK:
  - Occurs after REFRESH_DIV-BLANK_CYCLES cycles in SHOW.
  - If idx < NUM_DIGITS-1: idx <= idx+1.
  - Else (wrap): idx <= 0, snapshot <= i_digits, o_frame_tick=1 for exactly that one following cycle.
- Slot timing:
  - Each digit slot lasts exactly REFRESH_DIV cycles.
  - A frame lasts NUM_DIGITS*REFRESH_DIV cycles.
- o_digit_val update and input capture:
  - o_digit_val updates in the same cycle BLANK is entered, so it is stable at least BLANK_CYCLES cycles before the enable.
  - Changes to i_digits mid-frame have no effect until the next wrap.
- i_enable deassert (any state):
  - Next edge returns to IDLE; all digits off; idx and counter reset to 0.
  - No o_frame_tick is issued.
  - Re-enable restarts at digit 0 with a fresh snapshot.
- Overlap rules:
  - Never more than one digit enabled in any cycle.
  - Never an enable during BLANK.
- NUM_DIGITS=1: idx stays 0; every slot end is a wrap and pulses o_frame_tick.
- Reset mid-slot: all outputs return to reset values immediately (asynchronously).
- Counter width: $clog2(REFRESH_DIV). idx width: $clog2(NUM_DIGITS), minimum 1.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - At each snapshot, compute the highest nonzero digit index H, using 0 if all digits are zero.
  - In SHOW, digits with idx > H keep o_digit_en inactive.
  - Timing, idx sequencing and o_frame_tick are unchanged. Digit 0 always displays, so all-zero input shows a single "0".
- Not defined: every digit is enabled in its SHOW phase regardless of value.

Test Plan:
1. Reset and idle (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, DIGIT_ACTIVE_LOW=1): assert i_rst_n=0, then hold i_enable=0 for 20 cycles -> o_digit_en=4'b1111, o_digit_val=0, o_frame_tick=0 throughout.
2. Scan order: i_digits={3'd4,3'd3,3'd2,3'd1}, i_enable=1 ->
   - o_digit_val sequence 1,2,3,4.
   - Per slot: 2 cycles of 4'b1111, then 6 cycles of 4'b1110/1101/1011/0111 respectively.
   - o_frame_tick pulses once every 32 cycles.
3. Snapshot: change i_digits to all 3'd7 mid-frame at digit 1 -> digits 2 and 3 still show 3 and 4; the next frame shows 7,7,7,7.
4. Enable drop: deassert i_enable during digit 2's SHOW -> next cycle o_digit_en=4'b1111, no o_frame_tick; on re-enable the scan restarts at digit 0 after a 2-cycle blank.
5. Edge params: BLANK_CYCLES=0, NUM_DIGITS=1 -> o_digit_en constantly 1'b0 while enabled; o_frame_tick every 8 cycles.
6. LEADING_ZERO_BLANK_EN defined: i_digits={0,0,3'd5,3'd0} -> only digits 0 (shows 0) and 1 (shows 5) are enabled; digits 2 and 3 stay 1 for the whole slot; timing is identical to scenario 2.
